// File: rtl/multicycle_control_fsm.sv
// Main control FSM of the multicycle RV32I core: sequences ALU, unified memory port,
// PC, instruction register and register file, one state per cycle.
module multicycle_control_fsm #(
   parameter int STATE_W = 4
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic [6:0]         opcode,
   input  logic               mem_ready,
   input  logic               branch_cond,
   output logic               mem_read,
   output logic               mem_write,
   output logic               adr_src,
   output logic               ir_write,
   output logic               pc_update,
   output logic               reg_write,
   output logic [1:0]         alu_src_a,
   output logic [1:0]         alu_src_b,
   output logic [1:0]         alu_op,
   output logic [1:0]         result_src,
   output logic               instr_retired,
   output logic               illegal_instr,
   output logic [STATE_W-1:0] state
);

   typedef enum logic [3:0] {
      S_FETCH     = 4'd0,
      S_DECODE    = 4'd1,
      S_MEM_ADR   = 4'd2,
      S_MEM_READ  = 4'd3,
      S_MEM_WB    = 4'd4,
      S_MEM_WRITE = 4'd5,
      S_EXECUTE_R = 4'd6,
      S_EXECUTE_I = 4'd7,
      S_ALU_WB    = 4'd8,
      S_BRANCH    = 4'd9,
      S_JAL       = 4'd10,
      S_JALR      = 4'd11,
      S_LUI       = 4'd12,
      S_AUIPC     = 4'd13,
      S_TRAP      = 4'd14
   } state_t;

   typedef enum logic [1:0] {
      ALU_ADD    = 2'b00,
      ALU_BRANCH = 2'b01,
      ALU_REGOP  = 2'b10
   } alu_op_t;

   typedef struct packed {
      logic       mem_read;
      logic       mem_write;
      logic       adr_src;
      logic       ir_write;
      logic       pc_update;
      logic       reg_write;
      logic [1:0] src_a;
      logic [1:0] src_b;
      alu_op_t    alu_op;
      logic [1:0] result_src;
      logic       retire;
      logic       illegal;
   } ctrl_t;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_REG    = 7'b0110011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_FENCE  = 7'b0001111;

   state_t state_q, state_d;
   ctrl_t  ctrl_q;

   // Ungated Moore controls; input-dependent qualifiers are applied at the outputs.
   function automatic ctrl_t decode_ctrl(input state_t s);
      ctrl_t c;
      c = '0;
      c.alu_op = ALU_ADD;
      case (s)
         S_FETCH: begin
            c.mem_read   = 1'b1;
            c.ir_write   = 1'b1;
            c.pc_update  = 1'b1;
            c.src_b      = 2'b10;
            c.result_src = 2'b10;
         end
         S_DECODE: begin
            c.src_a = 2'b01;
            c.src_b = 2'b01;
         end
         S_MEM_ADR: begin
            c.src_a = 2'b10;
            c.src_b = 2'b01;
         end
         S_MEM_READ: begin
            c.adr_src  = 1'b1;
            c.mem_read = 1'b1;
         end
         S_MEM_WB: begin
            c.result_src = 2'b01;
            c.reg_write  = 1'b1;
            c.retire     = 1'b1;
         end
         S_MEM_WRITE: begin
            c.adr_src   = 1'b1;
            c.mem_write = 1'b1;
            c.retire    = 1'b1;
         end
         S_EXECUTE_R: begin
            c.src_a  = 2'b10;
            c.alu_op = ALU_REGOP;
         end
         S_EXECUTE_I: begin
            c.src_a  = 2'b10;
            c.src_b  = 2'b01;
            c.alu_op = ALU_REGOP;
         end
         S_ALU_WB: begin
            c.reg_write = 1'b1;
            c.retire    = 1'b1;
         end
         S_BRANCH: begin
            c.src_a     = 2'b10;
            c.alu_op    = ALU_BRANCH;
            c.pc_update = 1'b1;
            c.retire    = 1'b1;
         end
         S_JAL: begin
            c.src_a     = 2'b01;
            c.src_b     = 2'b10;
            c.pc_update = 1'b1;
         end
         S_JALR: begin
            c.src_a = 2'b10;
            c.src_b = 2'b01;
         end
         S_LUI: begin
            c.src_a = 2'b11;
            c.src_b = 2'b01;
         end
         S_AUIPC: begin
            c.src_a = 2'b01;
            c.src_b = 2'b01;
         end
         S_TRAP: c.illegal = 1'b1;
         default: c = '0;
      endcase
      return c;
   endfunction

   always_comb begin
      state_d = S_FETCH;
      case (state_q)
         S_FETCH:  state_d = mem_ready ? S_DECODE : S_FETCH;
         S_DECODE: begin
            case (opcode)
               OP_LOAD, OP_STORE: state_d = S_MEM_ADR;
               OP_REG:            state_d = S_EXECUTE_R;
               OP_IMM:            state_d = S_EXECUTE_I;
               OP_BRANCH:         state_d = S_BRANCH;
               OP_JAL:            state_d = S_JAL;
               OP_JALR:           state_d = S_JALR;
               OP_LUI:            state_d = S_LUI;
               OP_AUIPC:          state_d = S_AUIPC;
               OP_FENCE:          state_d = S_FETCH;
               default:           state_d = S_TRAP;
            endcase
         end
         S_MEM_ADR:   state_d = (opcode == OP_LOAD) ? S_MEM_READ : S_MEM_WRITE;
         S_MEM_READ:  state_d = mem_ready ? S_MEM_WB : S_MEM_READ;
         S_MEM_WB:    state_d = S_FETCH;
         S_MEM_WRITE: state_d = mem_ready ? S_FETCH : S_MEM_WRITE;
         S_EXECUTE_R, S_EXECUTE_I, S_JAL, S_LUI, S_AUIPC: state_d = S_ALU_WB;
         S_ALU_WB:    state_d = S_FETCH;
         S_BRANCH:    state_d = S_FETCH;
         S_JALR:      state_d = S_JAL;
         S_TRAP:      state_d = S_TRAP;
         default:     state_d = S_FETCH;
      endcase
   end

   // Controls are registered alongside the state they belong to.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q <= S_FETCH;
         ctrl_q  <= decode_ctrl(S_FETCH);
      end else begin
         state_q <= state_d;
         ctrl_q  <= decode_ctrl(state_d);
      end
   end

   logic in_fetch, in_branch, in_mem_write, fence_done;
   assign in_fetch     = (state_q == S_FETCH);
   assign in_branch    = (state_q == S_BRANCH);
   assign in_mem_write = (state_q == S_MEM_WRITE);
   assign fence_done   = (state_q == S_DECODE) && (opcode == OP_FENCE);

   assign mem_read   = reset_n & ctrl_q.mem_read;
   assign mem_write  = reset_n & ctrl_q.mem_write;
   assign ir_write   = reset_n & ctrl_q.ir_write & mem_ready;
   assign pc_update  = reset_n & ctrl_q.pc_update &
                       (in_fetch ? mem_ready : (in_branch ? branch_cond : 1'b1));
   assign reg_write  = reset_n & ctrl_q.reg_write;
   assign instr_retired = reset_n &
                          ((ctrl_q.retire & (in_mem_write ? mem_ready : 1'b1)) | fence_done);

   assign adr_src       = ctrl_q.adr_src;
   assign alu_src_a     = ctrl_q.src_a;
   assign alu_src_b     = ctrl_q.src_b;
   assign alu_op        = ctrl_q.alu_op;
   assign result_src    = ctrl_q.result_src;
   assign illegal_instr = ctrl_q.illegal;
   assign state         = STATE_W'(state_q);

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Scoreboarded random and directed test of multicycle_control_fsm: per-instruction
// expected traces are queued by the driver and compared cycle by cycle by a monitor.
module tb_multicycle_control_fsm;

   logic       clk = 1'b0;
   logic       reset_n;
   logic [6:0] opcode;
   logic       mem_ready;
   logic       branch_cond;
   logic       mem_read, mem_write, adr_src, ir_write, pc_update, reg_write;
   logic [1:0] alu_src_a, alu_src_b, alu_op, result_src;
   logic       instr_retired, illegal_instr;
   logic [3:0] state;

   multicycle_control_fsm #(.STATE_W(4)) dut (
      .clk(clk), .reset_n(reset_n), .opcode(opcode), .mem_ready(mem_ready),
      .branch_cond(branch_cond), .mem_read(mem_read), .mem_write(mem_write),
      .adr_src(adr_src), .ir_write(ir_write), .pc_update(pc_update),
      .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
      .alu_op(alu_op), .result_src(result_src), .instr_retired(instr_retired),
      .illegal_instr(illegal_instr), .state(state)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [6:0]       op;
      logic [4:0]       len;
      logic [23:0][3:0] path;
      logic [23:0]      mr;
      logic [23:0]      bcv;
   } rec_t;

   rec_t sb[$];
   int   tests = 0;
   int   fails = 0;
   logic mon_en = 1'b0;
   logic have = 1'b0;

   logic [6:0] legal_ops[10] = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011,
                                 7'b1100011, 7'b1101111, 7'b1100111, 7'b0110111,
                                 7'b0010111, 7'b0001111};

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [15:0] outs_now();
      return {mem_read, mem_write, adr_src, ir_write, pc_update, reg_write,
              alu_src_a, alu_src_b, alu_op, result_src, instr_retired, illegal_instr};
   endfunction

   function automatic logic [5:0] strobes_now();
      return {mem_read, mem_write, ir_write, pc_update, reg_write, instr_retired};
   endfunction

   // Control table for each state, with the input-dependent entries resolved.
   function automatic logic [15:0] exp_out(input logic [3:0] s, input logic mr,
                                           input logic bc, input logic [6:0] op);
      logic mrd, mwr, adr, irw, pcu, rgw, ret, ill;
      logic [1:0] a, b, aop, res;
      {mrd, mwr, adr, irw, pcu, rgw, ret, ill} = '0;
      {a, b, aop, res} = '0;
      case (s)
         4'd0:  begin mrd = 1; b = 2; res = 2; irw = mr; pcu = mr; end
         4'd1:  begin a = 1; b = 1; ret = (op == 7'b0001111); end
         4'd2:  begin a = 2; b = 1; end
         4'd3:  begin adr = 1; mrd = 1; end
         4'd4:  begin res = 1; rgw = 1; ret = 1; end
         4'd5:  begin adr = 1; mwr = 1; ret = mr; end
         4'd6:  begin a = 2; aop = 2; end
         4'd7:  begin a = 2; b = 1; aop = 2; end
         4'd8:  begin rgw = 1; ret = 1; end
         4'd9:  begin a = 2; aop = 1; pcu = bc; ret = 1; end
         4'd10: begin a = 1; b = 2; pcu = 1; end
         4'd11: begin a = 2; b = 1; end
         4'd12: begin a = 3; b = 1; end
         4'd13: begin a = 1; b = 1; end
         4'd14: ill = 1;
         default: ;
      endcase
      return {mrd, mwr, adr, irw, pcu, rgw, a, b, aop, res, ret, ill};
   endfunction

   // Expected state trace of one instruction from its class and stall counts.
   function automatic rec_t build(input logic [6:0] op, input int fs, input int ms,
                                  input logic bc);
      rec_t r;
      int n;
      logic [31:0] rnd;
      r = '0;
      r.op = op;
      rnd = $urandom;
      r.mr = rnd[23:0];
      rnd = $urandom;
      r.bcv = rnd[23:0];
      n = 0;
      for (int k = 0; k <= fs; k++) begin r.path[n] = 4'd0; r.mr[n] = (k == fs); n++; end
      r.path[n] = 4'd1; n++;
      case (op)
         7'b0000011: begin
            r.path[n] = 4'd2; n++;
            for (int k = 0; k <= ms; k++) begin r.path[n] = 4'd3; r.mr[n] = (k == ms); n++; end
            r.path[n] = 4'd4; n++;
         end
         7'b0100011: begin
            r.path[n] = 4'd2; n++;
            for (int k = 0; k <= ms; k++) begin r.path[n] = 4'd5; r.mr[n] = (k == ms); n++; end
         end
         7'b0110011: begin r.path[n] = 4'd6; n++; r.path[n] = 4'd8; n++; end
         7'b0010011: begin r.path[n] = 4'd7; n++; r.path[n] = 4'd8; n++; end
         7'b1100011: begin r.path[n] = 4'd9; r.bcv[n] = bc; n++; end
         7'b1101111: begin r.path[n] = 4'd10; n++; r.path[n] = 4'd8; n++; end
         7'b1100111: begin
            r.path[n] = 4'd11; n++; r.path[n] = 4'd10; n++; r.path[n] = 4'd8; n++;
         end
         7'b0110111: begin r.path[n] = 4'd12; n++; r.path[n] = 4'd8; n++; end
         7'b0010111: begin r.path[n] = 4'd13; n++; r.path[n] = 4'd8; n++; end
         default: ;
      endcase
      r.len = 5'(n);
      return r;
   endfunction

   task automatic run_instr(input logic [6:0] op, input int fs, input int ms, input logic bc);
      rec_t r;
      r = build(op, fs, ms, bc);
      opcode = op;
      sb.push_back(r);
      for (int j = 0; j < int'(r.len); j++) begin
         mem_ready   = r.mr[j];
         branch_cond = r.bcv[j];
         @(posedge clk); #1;
      end
   endtask

   initial begin : monitor
      rec_t cur;
      int   i;
      logic [3:0] es;
      cur = '0;
      i = 0;
      forever begin
         @(negedge clk);
         if (mon_en) begin
            if (!have && sb.size() > 0) begin
               cur = sb.pop_front();
               have = 1'b1;
               i = 0;
            end
            if (have) begin
               es = cur.path[i];
               chk($sformatf("trace op=%b cyc%0d {state,ctrl}", cur.op, i),
                   {12'd0, state, outs_now()},
                   {12'd0, es, exp_out(es, cur.mr[i], cur.bcv[i], cur.op)});
               i++;
               if (i == int'(cur.len)) have = 1'b0;
            end
         end
      end
   end

   initial begin : driver
      reset_n = 1'b0;
      opcode = 7'b0110011;
      mem_ready = 1'b1;
      branch_cond = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("reset_state", 32'(state), 32'd0);
      chk("reset_strobes", 32'(strobes_now()), 32'd0);
      chk("reset_illegal", 32'(illegal_instr), 32'd0);
      @(posedge clk); #1;
      reset_n = 1'b1;
      mon_en = 1'b1;

      run_instr(7'b0110011, 0, 0, 1'b0);
      run_instr(7'b0000011, 0, 3, 1'b0);
      run_instr(7'b0100011, 1, 0, 1'b0);
      run_instr(7'b1100011, 0, 0, 1'b0);
      run_instr(7'b1100011, 0, 0, 1'b1);
      run_instr(7'b1100111, 0, 0, 1'b0);
      run_instr(7'b1101111, 0, 0, 1'b0);
      run_instr(7'b0110111, 0, 0, 1'b0);
      run_instr(7'b0010111, 0, 0, 1'b0);
      run_instr(7'b0001111, 0, 0, 1'b0);
      run_instr(7'b0010011, 2, 0, 1'b0);
      run_instr(7'b0100011, 0, 3, 1'b0);
      for (int t = 0; t < 150; t++)
         run_instr(legal_ops[$urandom_range(0, 9)], $urandom_range(0, 3),
                   $urandom_range(0, 3), 1'($urandom_range(0, 1)));
      mon_en = 1'b0;
      chk("scoreboard_drained", 32'(sb.size()) + 32'(have), 32'd0);

      // Illegal opcode: DECODE then TRAP until reset.
      opcode = 7'b1111111;
      mem_ready = 1'b1;
      @(negedge clk);
      chk("trap_fetch_state", 32'(state), 32'd0);
      @(posedge clk); #1;
      @(negedge clk);
      chk("trap_decode_state", 32'(state), 32'd1);
      @(posedge clk); #1;
      for (int k = 0; k < 10; k++) begin
         mem_ready = 1'($urandom_range(0, 1));
         branch_cond = 1'($urandom_range(0, 1));
         @(negedge clk);
         chk("trap_hold {state,illegal,strobes}",
             {21'd0, state, illegal_instr, strobes_now()}, {21'd0, 4'd14, 1'b1, 6'd0});
         @(posedge clk); #1;
      end
      reset_n = 1'b0;
      mem_ready = 1'b1;
      @(negedge clk);
      chk("trap_reset_strobes", 32'(strobes_now()), 32'd0);
      @(posedge clk); #1;
      reset_n = 1'b1;
      @(negedge clk);
      chk("trap_reset {state,illegal}", {27'd0, state, illegal_instr}, {27'd0, 4'd0, 1'b0});

      // Reset while a store is in MEM_WRITE.
      @(posedge clk); #1;
      opcode = 7'b0100011;
      mem_ready = 1'b1;
      repeat (2) begin @(posedge clk); #1; end
      @(negedge clk);
      chk("midst_state", 32'(state), 32'd5);
      chk("midst_mem_write", 32'(mem_write), 32'd1);
      reset_n = 1'b0;
      #1;
      chk("midst_reset {mem_write,retired}", {30'd0, mem_write, instr_retired}, 32'd0);
      @(posedge clk); #1;
      reset_n = 1'b1;
      @(negedge clk);
      chk("midst_after_state", 32'(state), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
